// File: rtl/dma_periph_arb.sv
// DMA peripheral request arbiter: synchronises peripheral request lines, walks each
// channel through request/transfer/clear/release and offers one registered grant at a time.
module dma_periph_arb #(
  parameter int NUM_CH      = 8,
  parameter int NUM_PERIPH  = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PSEL_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_PERIPH-1:0]    periph_req_i,
  output logic [NUM_PERIPH-1:0]    periph_clr_o,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH*PSEL_W-1:0] ch_periph_sel_i,
  input  logic [NUM_CH-1:0]        ch_done_i,
  output logic                     gnt_valid_o,
  output logic [CH_W-1:0]          gnt_ch_o,
  input  logic                     gnt_ready_i,
  output logic [NUM_CH-1:0]        ch_active_o,
  output logic                     idle_o
);

  typedef enum logic [2:0] {IDLE, PEND, ACTIVE, CLR, WAIT_LOW} chState_e;

  logic [NUM_PERIPH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PERIPH-1:0] sreq;
  chState_e              state_q [NUM_CH];
  chState_e              state_d [NUM_CH];
  logic [PSEL_W-1:0]     sel [NUM_CH];
  logic [NUM_CH-1:0]     selReq;
  logic [NUM_PERIPH-1:0] periphClr_q, periphClr_d;
  logic                  gntValid_q, gntValid_d;
  logic [CH_W-1:0]       gntCh_q, gntCh_d;
  logic [CH_W-1:0]       rrPtr_q, rrPtr_d;
  logic                  handshake;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= periph_req_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sreq      = sync_q[SYNC_STAGES-1];
  assign handshake = gntValid_q & gnt_ready_i;

  // Out-of-range selects never match a line, so such a channel reads its request as low.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]    = ch_periph_sel_i[i*PSEL_W +: PSEL_W];
      selReq[i] = 1'b0;
      for (int p = 0; p < NUM_PERIPH; p++) begin
        if (int'(sel[i]) == p) selReq[i] = sreq[p];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (ch_en_i[i] && selReq[i]) state_d[i] = PEND;
        end
        PEND: begin
          if (handshake && int'(gntCh_q) == i) state_d[i] = ACTIVE;
          else if (!ch_en_i[i])                state_d[i] = IDLE;
        end
        ACTIVE: begin
          if (ch_done_i[i]) state_d[i] = CLR;
        end
        CLR: begin
          state_d[i] = WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!selReq[i]) state_d[i] = IDLE;
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Clear pulse is registered from the next state so it coincides with the CLR cycle.
  always_comb begin
    periphClr_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int p = 0; p < NUM_PERIPH; p++) begin
        if (state_d[i] == CLR && int'(sel[i]) == p) periphClr_d[p] = 1'b1;
      end
    end
  end

  always_comb begin
    int  idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    gntValid_d = 1'b0;
    gntCh_d    = gntCh_q;
    rrPtr_d    = rrPtr_q;
    if (gntValid_q) begin
      if (handshake) begin
        rrPtr_d = (gntCh_q == CH_W'(NUM_CH-1)) ? '0 : gntCh_q + CH_W'(1);
      end else if (ch_en_i[gntCh_q]) begin
        gntValid_d = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rrPtr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && state_q[idx] == PEND && ch_en_i[idx]) begin
          found      = 1'b1;
          gntValid_d = 1'b1;
          gntCh_d    = CH_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= IDLE;
      periphClr_q <= '0;
      gntValid_q  <= 1'b0;
      gntCh_q     <= '0;
      rrPtr_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
      periphClr_q <= periphClr_d;
      gntValid_q  <= gntValid_d;
      gntCh_q     <= gntCh_d;
      rrPtr_q     <= rrPtr_d;
    end
  end

  always_comb begin
    idle_o      = 1'b1;
    ch_active_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_active_o[i] = (state_q[i] == ACTIVE);
      if (state_q[i] != IDLE) idle_o = 1'b0;
    end
  end

  assign periph_clr_o = periphClr_q;
  assign gnt_valid_o  = gntValid_q;
  assign gnt_ch_o     = gntCh_q;

endmodule

// File: doc/dma_periph_arb.md
DMA_PERIPH_ARB -- requirements
Module: dma_periph_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of DMA channels (1..32).
REQ-002 SHALL have parameter NUM_PERIPH, default 16, number of peripheral request lines (1..32).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, depth of the periph_req synchroniser (>=2).
REQ-004 SHALL derive local widths CH_W = max(1,$clog2(NUM_CH)) and PSEL_W = max(1,$clog2(NUM_PERIPH)).
REQ-005 clk  in  1  single clock; all flops on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 periph_req  in  NUM_PERIPH  asynchronous level requests from peripherals.
REQ-008 periph_clr  out  NUM_PERIPH  registered one-cycle clear pulses to peripherals.
REQ-009 ch_en  in  NUM_CH  per-channel enable.
REQ-010 ch_periph_sel  in  NUM_CH*PSEL_W  peripheral index per channel; channel i uses bits [i*PSEL_W +: PSEL_W].
REQ-011 ch_done  in  NUM_CH  one-cycle pulse from channel engine: transfer for channel i complete.
REQ-012 gnt_valid  out  1  grant offer to channel engine.
REQ-013 gnt_ch  out  CH_W  channel index offered.
REQ-014 gnt_ready  in  1  engine accepts the offered grant.
REQ-015 ch_active  out  NUM_CH  channel i is in ACTIVE.
REQ-016 idle  out  1  high when every channel is in IDLE.

Function
REQ-017 SHALL pass each periph_req bit through SYNC_STAGES flops; only the synchronised value (sreq) SHALL be used.
REQ-018 Each channel SHALL run an FSM with states IDLE, PEND, ACTIVE, CLR, WAIT_LOW.
REQ-019 IDLE->PEND when ch_en[i]=1, sel[i]<NUM_PERIPH and sreq[sel[i]]=1; sel>=NUM_PERIPH SHALL hold the channel in IDLE.
REQ-020 PEND->IDLE when ch_en[i]=0; PEND->ACTIVE on the cycle gnt_valid & gnt_ready & gnt_ch==i.
REQ-021 ACTIVE->CLR on ch_done[i]=1; ch_en deassertion SHALL NOT affect ACTIVE; ch_done in any other state SHALL be ignored.
REQ-022 CLR SHALL last exactly one cycle and drive periph_clr[sel[i]]=1 during it, then go to WAIT_LOW.
REQ-023 WAIT_LOW->IDLE when sreq[sel[i]]=0, preventing re-triggering on a stale level.
REQ-024 periph_clr SHALL be the OR of all channels in CLR; two channels clearing the same line in one cycle give one pulse.
REQ-025 Arbiter SHALL select among PEND channels round-robin, starting search at rr_ptr; gnt_valid/gnt_ch SHALL be registered.
REQ-026 Once gnt_valid=1, gnt_ch SHALL remain stable and gnt_valid high until gnt_ready=1, unless the offered channel leaves PEND (ch_en=0), in which case gnt_valid SHALL drop next cycle.
REQ-027 On handshake rr_ptr SHALL become (gnt_ch+1) mod NUM_CH, wrapping NUM_CH-1 -> 0; gnt_valid SHALL drop for at least one cycle after each handshake.
REQ-028 Latency, SYNC_STAGES=2, idle arbiter: periph_req high before edge 1 -> sreq after edge 2 -> PEND after edge 3 -> gnt_valid after edge 4.
REQ-029 ch_active = one-hot-per-channel decode of ACTIVE; idle = AND of all channels in IDLE, combinational from state flops.
REQ-030 Multiple channels MAY be ACTIVE concurrently; at most one grant offer SHALL exist at a time.

Reset
REQ-031 reset=0 SHALL asynchronously force all FSMs to IDLE, synchroniser flops to 0, rr_ptr=0, gnt_valid=0, gnt_ch=0, periph_clr=0, ch_active=0, idle=1.
REQ-032 Reset asserted mid-transfer SHALL discard pending/active state without issuing periph_clr; release SHALL be synchronous to clk via normal flop sampling.

Verification
REQ-033 Single request: ch0 en, sel=3, periph_req[3]=1, gnt_ready=1 -> gnt_valid,gnt_ch=0 4 cycles later; ch_done -> periph_clr[3] one cycle; ch0 in WAIT_LOW until req drops, then idle=1.
REQ-034 Round robin: ch0,ch2,ch5 pending, gnt_ready=1 -> grants 0,2,5; repeat with rr_ptr=6 -> grants 0,2,5 after wrap.
REQ-035 Backpressure: gnt_ready=0 10 cycles with ch1 pending -> gnt_valid high, gnt_ch=1 stable throughout; ch1 en dropped -> gnt_valid low next cycle, ch1 IDLE.
REQ-036 Shared line: ch3, ch4 sel=7, both done same cycle -> single periph_clr[7] pulse; both WAIT_LOW until periph_req[7]=0.
REQ-037 Boundaries: sel=NUM_PERIPH -> never PEND; ch_done in PEND ignored; reset=0 while ACTIVE -> all outputs reset values, no periph_clr.
